id_stage_hs: RTL



---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/id_stage_hs_regfile_bp.sv | 48 ++++
 rtl/id_stage_hs.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions: instruction field positions, operand-source select and forwarding priority.
package cpu_pkg;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_W  = 16;
  localparam int JIDX_W = 26;

  localparam int CTRL_W_DFLT = 20;

  // Fixed-width envelope for the priority function; callers zero-pad into it.
  localparam int FWD_MAX = 8;
  localparam int RA_MAX  = 5;

  typedef enum logic [1:0] {SEL_RF, SEL_WB, SEL_FWD} fwd_sel_t;

  typedef struct packed {
    fwd_sel_t   sel;
    logic [2:0] slot;
  } fwd_pick_t;

  // Lowest-index matching slot wins, then the write-back port, then the register file.
  function automatic fwd_pick_t fwd_pick(
    input logic [FWD_MAX-1:0]        vld,
    input logic [FWD_MAX*RA_MAX-1:0] regs,
    input logic [RA_MAX-1:0]         src,
    input logic                      wb_we,
    input logic [RA_MAX-1:0]         wb_addr
  );
    fwd_pick_t p;
    p.sel  = SEL_RF;
    p.slot = '0;
    if (src != '0) begin
      if (wb_we && (wb_addr == src)) p.sel = SEL_WB;
      for (int k = FWD_MAX - 1; k >= 0; k--) begin
        if (vld[k] && (regs[k*RA_MAX +: RA_MAX] == src)) begin
          p.sel  = SEL_FWD;
          p.slot = 3'(k);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/id_stage_hs_regfile_bp.sv
// Architectural register file: two async read ports, one sync write port with write-first bypass.
// Register 0 is hardwired to zero; synchronous reset clears every entry and blocks the write.
module regfile_bp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RA_W-1:0] raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [RA_W-1:0] raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  always_comb begin
    rf_d = rf_q;
    if (we && (waddr != '0)) rf_d[waddr] = wdata;
    rf_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rdata_a = rf_q[raddr_a];
    if (we && (waddr == raddr_a)) rdata_a = wdata;
    if (raddr_a == '0) rdata_a = '0;
  end

  always_comb begin
    rdata_b = rf_q[raddr_b];
    if (we && (waddr == raddr_b)) rdata_b = wdata;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/id_stage_hs.sv
// Handshaked ID stage: operand read with forwarding select, load-use interlock, ID/EX output register.
// Latency 1 cycle; in_ready drops under load-use hazard, flush, or a held (unaccepted) output.
module id_stage_hs
  import cpu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NFWD   = 3,
  parameter int CTRL_W = CTRL_W_DFLT,
  parameter int CNT_W  = 16,
  parameter int RA_W   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc_next,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RA_W-1:0] fwd_reg,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 ld_valid,
  input  logic [RA_W-1:0]      ld_reg,
  input  logic                 wb_we,
  input  logic [RA_W-1:0]      wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [XLEN-1:0]      out_data_s,
  output logic [XLEN-1:0]      out_data_t,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_pc_jump,
  output logic [XLEN-1:0]      out_pc_next,
  output logic [5:0]           out_opcode,
  output logic [RA_W-1:0]      out_rs,
  output logic [RA_W-1:0]      out_rt,
  output logic [RA_W-1:0]      out_rd,
  output logic [CNT_W-1:0]     stall_count
);

  logic [RA_W-1:0] rs, rt, rd;
  logic [XLEN-1:0] rf_s, rf_t;
  logic [XLEN-1:0] opnd_s, opnd_t;
  logic [XLEN-1:0] imm_ext, pc_jump;
  logic            hazard, adv, accept;

  logic [FWD_MAX-1:0]        fwd_vld_pad;
  logic [FWD_MAX*RA_MAX-1:0] fwd_reg_pad;
  fwd_pick_t                 pick_s, pick_t;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   ds_q, ds_d, dt_q, dt_d, imm_q, imm_d;
  logic [XLEN-1:0]   pcj_q, pcj_d, pcn_q, pcn_d;
  logic [5:0]        op_q, op_d;
  logic [RA_W-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign rs = in_instr[RS_LO +: RA_W];
  assign rt = in_instr[RT_LO +: RA_W];
  assign rd = in_instr[RD_LO +: RA_W];

  assign imm_ext = {{(XLEN-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
  assign pc_jump = {in_pc_next[XLEN-1:28], in_instr[JIDX_W-1:0], 2'b00};

  regfile_bp #(.XLEN(XLEN), .NREG(NREG), .RA_W(RA_W)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .rdata_a (rf_s),
    .raddr_b (rt),
    .rdata_b (rf_t)
  );

  always_comb begin
    fwd_vld_pad = FWD_MAX'(fwd_valid);
    fwd_reg_pad = '0;
    for (int k = 0; k < NFWD; k++) begin
      fwd_reg_pad[k*RA_MAX +: RA_MAX] = RA_MAX'(fwd_reg[k*RA_W +: RA_W]);
    end
  end

  assign pick_s = fwd_pick(fwd_vld_pad, fwd_reg_pad, RA_MAX'(rs), wb_we, RA_MAX'(wb_addr));
  assign pick_t = fwd_pick(fwd_vld_pad, fwd_reg_pad, RA_MAX'(rt), wb_we, RA_MAX'(wb_addr));

  always_comb begin
    opnd_s = rf_s;
    opnd_t = rf_t;
    if (pick_s.sel == SEL_WB) opnd_s = wb_data;
    if (pick_t.sel == SEL_WB) opnd_t = wb_data;
    for (int k = 0; k < NFWD; k++) begin
      if ((pick_s.sel == SEL_FWD) && (pick_s.slot == 3'(k))) opnd_s = fwd_data[k*XLEN +: XLEN];
      if ((pick_t.sel == SEL_FWD) && (pick_t.slot == 3'(k))) opnd_t = fwd_data[k*XLEN +: XLEN];
    end
  end

  // rt is compared even for formats that do not read it; a spurious stall is harmless.
  assign hazard   = in_valid && ld_valid && (ld_reg != '0) && ((ld_reg == rs) || (ld_reg == rt));
  assign adv      = !valid_q || out_ready;
  assign in_ready = adv && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    ds_d    = ds_q;
    dt_d    = dt_q;
    imm_d   = imm_q;
    pcj_d   = pcj_q;
    pcn_d   = pcn_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    stall_d = stall_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      ds_d    = opnd_s;
      dt_d    = opnd_t;
      imm_d   = imm_ext;
      pcj_d   = pc_jump;
      pcn_d   = in_pc_next;
      op_d    = in_instr[OP_HI:OP_LO];
      rs_d    = rs;
      rt_d    = rt;
      rd_d    = rd;
    end else if (adv) begin
      // Bubble: data fields keep their last values.
      valid_d = 1'b0;
    end

    if (hazard && adv && !flush && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      ds_q    <= '0;
      dt_q    <= '0;
      imm_q   <= '0;
      pcj_q   <= '0;
      pcn_q   <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      ds_q    <= ds_d;
      dt_q    <= dt_d;
      imm_q   <= imm_d;
      pcj_q   <= pcj_d;
      pcn_q   <= pcn_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_ctrl    = ctrl_q;
  assign out_data_s  = ds_q;
  assign out_data_t  = dt_q;
  assign out_imm     = imm_q;
  assign out_pc_jump = pcj_q;
  assign out_pc_next = pcn_q;
  assign out_opcode  = op_q;
  assign out_rs      = rs_q;
  assign out_rt      = rt_q;
  assign out_rd      = rd_q;
  assign stall_count = stall_q;

endmodule
